// File: rtl/muldiv_pkg.sv
// Shared widths, opcode/state encodings and sign helpers for the HI/LO multiply-divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned XLEN2 = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Magnitude of a two's-complement operand; unsigned ops pass through untouched.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [XLEN2-1:0] neg2x(input logic [XLEN2-1:0] x);
    return ~x + XLEN2'(1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the {acc, lo} work pair.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc_c,
  output logic [XLEN-1:0] o_lo_c
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // The shifted remainder can reach XLEN+1 bits; the difference always fits XLEN once w_ge holds.
  always_comb begin
    w_sum    = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = {i_acc, i_lo[XLEN-1]};
    w_ge     = (w_rem_sh >= {1'b0, i_opnd});
    w_diff   = w_rem_sh[XLEN-1:0] - i_opnd;
    if (i_is_div) begin
      o_acc_c = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
      o_lo_c  = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_acc_c = w_sum[XLEN:1];
      o_lo_c  = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU; owns HI/LO and the EX stall.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  input  logic            hilo_we,
  input  logic            hilo_sel,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_MUL   = 3'(ST_MUL);
  localparam logic [2:0] S_DIV   = 3'(ST_DIV);
  localparam logic [2:0] S_FIXUP = 3'(ST_FIXUP);
  localparam logic [2:0] S_DONE  = 3'(ST_DONE);

  logic [2:0]       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc, r_wlo, r_opnd, r_hi, r_lo;
  logic             r_is_div, r_neg_lo, r_neg_hi, r_done, r_dbz;
  logic             w_op_div, w_op_signed, w_load, w_dbz_start, w_iter, w_fix_load, w_hilo_ok;
  logic [XLEN-1:0]  w_abs_rs, w_abs_rt, w_step_acc, w_step_lo, w_fix_hi, w_fix_lo;
  logic [XLEN2-1:0] w_prod;

  assign w_op_div    = (op_e'(op) == OP_DIV) || (op_e'(op) == OP_DIVU);
  assign w_op_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  assign w_abs_rs    = abs_val(rs_val, w_op_signed);
  assign w_abs_rt    = abs_val(rt_val, w_op_signed);

  muldiv_step u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_lo     (r_wlo),
    .i_opnd   (r_opnd),
    .o_acc_c  (w_step_acc),
    .o_lo_c   (w_step_lo)
  );

  // Sign correction of the unsigned magnitude result.
  always_comb begin
    w_prod = r_neg_lo ? neg2x({r_acc, r_wlo}) : {r_acc, r_wlo};
    if (r_is_div) begin
      w_fix_lo = r_neg_lo ? (~r_wlo + XLEN'(1)) : r_wlo;
      w_fix_hi = r_neg_hi ? (~r_acc + XLEN'(1)) : r_acc;
    end else begin
      w_fix_hi = w_prod[XLEN2-1:XLEN];
      w_fix_lo = w_prod[XLEN-1:0];
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_dbz_start = 1'b0;
    w_iter      = 1'b0;
    w_fix_load  = 1'b0;
    w_hilo_ok   = 1'b0;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hilo_ok = 1'b1;
        stall     = start;
        if (start && !flush) begin
          if (w_op_div && (rt_val == '0)) begin
            w_dbz_start = 1'b1;
            w_next      = S_DONE;
          end else begin
            w_load = 1'b1;
            w_next = w_op_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        stall  = 1'b1;
        w_iter = 1'b1;
        if (flush)            w_next = S_IDLE;
        else if (r_cnt == '0) w_next = S_FIXUP;
      end
      S_FIXUP: begin
        stall = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          w_fix_load = 1'b1;
          w_next     = S_DONE;
        end
      end
      S_DONE: begin
        w_hilo_ok = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_wlo    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= (w_next == S_DONE);
      r_dbz  <= w_dbz_start;
      if (w_load) begin
        r_cnt    <= CNT_W'(XLEN - 1);
        r_acc    <= '0;
        r_wlo    <= w_op_div ? w_abs_rs : w_abs_rt;
        r_opnd   <= w_op_div ? w_abs_rt : w_abs_rs;
        r_is_div <= w_op_div;
        r_neg_lo <= w_op_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
        r_neg_hi <= w_op_signed && w_op_div && rs_val[XLEN-1];
      end else if (w_iter) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_acc <= w_step_acc;
        r_wlo <= w_step_lo;
      end
      // A starting op or a finishing result wins over a same-cycle MTHI/MTLO.
      if (w_dbz_start) begin
        r_hi <= rs_val;
        r_lo <= '1;
      end else if (w_fix_load) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (hilo_we && w_hilo_ok) begin
        if (hilo_sel) r_hi <= hilo_wdata;
        else          r_lo <= hilo_wdata;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a cycle-counting arithmetic model of HI/LO.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start, flush, hilo_we, hilo_sel;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val, rt_val, hilo_wdata;
  logic            stall, busy, done, div_by_zero;
  logic [XLEN-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endfunction

  // Reference result straight from integer arithmetic (divisor assumed non-zero).
  function automatic void ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] eh, output logic [31:0] el);
    longint     la, lb, lq, lr;
    logic [63:0] t, t2;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (o)
      2'b00: begin t = 64'(la * lb); eh = t[63:32]; el = t[31:0]; end
      2'b01: begin t = {32'b0, a} * {32'b0, b}; eh = t[63:32]; el = t[31:0]; end
      2'b10: begin lq = la / lb; lr = la % lb; t = 64'(lq); t2 = 64'(lr); el = t[31:0]; eh = t2[31:0]; end
      default: begin el = a / b; eh = a % b; end
    endcase
  endfunction

  // Model: mode 0 idle, 1 computing (m_t counts cycles since start), 2 done cycle.
  int          m_mode;
  int          m_t;
  logic        m_dbz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_t = 0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      case (m_mode)
        0: begin
          if (hilo_we) begin if (hilo_sel) m_hi = hilo_wdata; else m_lo = hilo_wdata; end
          if (start && !flush) begin
            if (op[1] && rt_val == 32'h0) begin
              m_hi = rs_val; m_lo = 32'hFFFF_FFFF; m_dbz = 1'b1; m_mode = 2;
            end else begin
              ref_result(op, rs_val, rt_val, p_hi, p_lo);
              m_dbz = 1'b0; m_t = 1; m_mode = 1;
            end
          end
        end
        1: begin
          if (flush) m_mode = 0;
          else if (m_t == XLEN + 1) begin m_hi = p_hi; m_lo = p_lo; m_mode = 2; end
          else m_t++;
        end
        default: begin
          if (hilo_we) begin if (hilo_sel) m_hi = hilo_wdata; else m_lo = hilo_wdata; end
          m_mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(m_mode == 1 || (m_mode == 0 && start)));
    chk("busy",  32'(busy),  32'(m_mode != 0));
    chk("done",  32'(done),  32'(m_mode == 2));
    chk("dbz",   32'(div_by_zero), 32'(m_mode == 2 && m_dbz));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Follows an op already presented this cycle; cycle 0 is the start cycle.
  task automatic wait_op(input bit noisy, output int dcyc, output int scnt, output bit dbz);
    bit fin;
    fin = 0; dcyc = -1; scnt = 0; dbz = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      if (stall) scnt++;
      if (done) begin dcyc = c; dbz = div_by_zero; fin = 1; end
      else if (c > 0 && !busy) fin = 1;
      tick();
      start = 0; hilo_we = 0; flush = 0;
      if (noisy && !fin) begin
        start = ($urandom_range(0, 3) == 0); op = 2'($urandom);
        rs_val = $urandom; rt_val = $urandom;
        hilo_we = ($urandom_range(0, 3) == 0); hilo_sel = 1'($urandom); hilo_wdata = $urandom;
        flush = ($urandom_range(0, 199) == 0);
      end
    end
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL op_timeout t=%0t got=busy expected=idle", $time); end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output int scnt, output bit dbz);
    op = o; rs_val = a; rt_val = b; start = 1;
    wait_op(0, dcyc, scnt, dbz);
  endtask

  task automatic drain();
    for (int c = 0; c < 80 && busy; c++) tick();
  endtask

  initial begin
    int dcyc, scnt;
    bit dbz;
    logic [31:0] eh, el;

    reset = 0; start = 0; flush = 0; hilo_we = 0; hilo_sel = 0;
    op = 2'b00; rs_val = '0; rt_val = '0; hilo_wdata = '0;
    repeat (2) tick();
    chk("reset_hi", hi, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1;
    tick();

    ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el);
    chk("model_multu_hi", eh, 32'hFFFF_FFFE); chk("model_multu_lo", el, 32'h1);
    ref_result(2'b10, 32'hFFFF_FFF9, 32'h2, eh, el);
    chk("model_div_hi", eh, 32'hFFFF_FFFF); chk("model_div_lo", el, 32'hFFFF_FFFD);
    ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, eh, el);
    chk("model_ovf_hi", eh, 32'h0); chk("model_ovf_lo", el, 32'h8000_0000);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, scnt, dbz);
    chk("t1_done_cycle", 32'(dcyc), 32'd34); chk("t1_stall_cycles", 32'(scnt), 32'd34);
    chk("t1_hi", hi, 32'hFFFF_FFFE); chk("t1_lo", lo, 32'h1); chk("t1_dbz", 32'(dbz), 32'h0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'h5, dcyc, scnt, dbz);
    chk("t2a_hi", hi, 32'hFFFF_FFFF); chk("t2a_lo", lo, 32'hFFFF_FFF1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, dcyc, scnt, dbz);
    chk("t2b_hi", hi, 32'h4000_0000); chk("t2b_lo", lo, 32'h0);

    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, dcyc, scnt, dbz);
    chk("t3a_hi", hi, 32'hFFFF_FFFF); chk("t3a_lo", lo, 32'hFFFF_FFFD);
    run_op(2'b11, 32'h7, 32'h2, dcyc, scnt, dbz);
    chk("t3b_hi", hi, 32'h1); chk("t3b_lo", lo, 32'h3);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dcyc, scnt, dbz);
    chk("t3c_hi", hi, 32'h0); chk("t3c_lo", lo, 32'h8000_0000);

    run_op(2'b10, 32'h1234, 32'h0, dcyc, scnt, dbz);
    chk("t4_done_cycle", 32'(dcyc), 32'd1); chk("t4_stall_cycles", 32'(scnt), 32'd1);
    chk("t4_dbz", 32'(dbz), 32'h1); chk("t4_hi", hi, 32'h1234); chk("t4_lo", lo, 32'hFFFF_FFFF);

    hilo_we = 1; hilo_sel = 1; hilo_wdata = 32'hAAAA; tick();
    hilo_sel = 0; hilo_wdata = 32'h5555; tick();
    hilo_we = 0;
    op = 2'b00; rs_val = 32'h7; rt_val = 32'h9; start = 1; tick();
    start = 0;
    repeat (9) tick();
    flush = 1; tick();
    flush = 0;
    @(negedge clk);
    chk("t5_busy_after_flush", 32'(busy), 32'h0);
    chk("t5_hi", hi, 32'hAAAA); chk("t5_lo", lo, 32'h5555);
    tick();
    start = 1; tick();
    start = 0;
    repeat (9) tick();
    reset = 0; #1;
    chk("t5_rst_hi", hi, 32'h0); chk("t5_rst_lo", lo, 32'h0);
    chk("t5_rst_stall", 32'(stall), 32'h0); chk("t5_rst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1; tick();

    hilo_we = 1; hilo_sel = 1; hilo_wdata = 32'hDEAD;
    op = 2'b01; rs_val = 32'h2; rt_val = 32'h3; start = 1; tick();
    start = 0; hilo_we = 0;
    chk("t6_hi_write", hi, 32'hDEAD);
    tick();
    hilo_we = 1; hilo_sel = 0; hilo_wdata = 32'hFFFF; tick();
    hilo_we = 0;
    chk("t6_we_ignored", lo, 32'h0);
    wait_op(0, dcyc, scnt, dbz);
    chk("t6_hi", hi, 32'h0); chk("t6_lo", lo, 32'h6);

    for (int i = 0; i < 60; i++) begin
      hilo_we = ($urandom_range(0, 3) == 0); hilo_sel = 1'($urandom); hilo_wdata = $urandom;
      run_op_noisy: begin
        op = 2'($urandom); rs_val = pick(); rt_val = pick(); start = 1;
        wait_op(1, dcyc, scnt, dbz);
      end
      drain();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
